seg_scan_mux: RTL

//  Parametrised multiplexed 7-segment scanner, successor to the fixed 4-digit BCD display driver.
//  - Time-multiplexes NUM_DIGITS nibbles onto one active-low segment bus, using an internal refresh prescaler.
//  - Double-buffers display data, so frames are never torn.
//  - Adds hex decode, per-digit blink and per-digit decimal point.
//  - Sits between the clock/time counters and the board anodes/cathodes.

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_mux.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Purely combinational nibble to active-low 7-segment pattern (full hex).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered, time-multiplexed 7-segment scanner with hex decode, blink and dp.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic                    upd_i,
    output logic                    upd_pend_o,
    output logic                    frame_o,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx, idx_nxt;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase, phase_nxt;
    logic                    tick, last_digit, boundary, load;

    logic [4*NUM_DIGITS-1:0] stg_digits, sh_digits, sh_digits_nxt;
    logic [NUM_DIGITS-1:0]   stg_dp, sh_dp, sh_dp_nxt;
    logic [NUM_DIGITS-1:0]   stg_blink, sh_blink, sh_blink_nxt;
    logic                    pend;

    logic [3:0]              nibble;
    logic [6:0]              dec_seg;
    logic                    blink_blank, lz_blank;

    assign tick       = (presc == PW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign boundary   = tick && last_digit;
    assign idx_nxt    = last_digit ? '0 : idx + 1'b1;

    // Update handshake: upd_i is a one-cycle strobe that always lands in staging
    // and raises pend; a frame boundary with pend high copies staging into the
    // shadow (the only thing displayed) and drops pend, unless a new strobe
    // arrives on that same cycle, which re-stages and keeps pend high.
    assign load          = boundary && pend;
    assign sh_digits_nxt = load ? stg_digits : sh_digits;
    assign sh_dp_nxt     = load ? stg_dp     : sh_dp;
    assign sh_blink_nxt  = load ? stg_blink  : sh_blink;
    assign upd_pend_o    = pend;

    assign phase_nxt = (boundary && blink_cnt == BW'(BLINK_DIV - 1)) ? ~blink_phase : blink_phase;

    // Next slot's digit is decoded from next-state shadow so a new frame shows new data.
    assign nibble      = sh_digits_nxt[4*int'(idx_nxt) +: 4];
    assign blink_blank = phase_nxt && sh_blink_nxt[idx_nxt];

    seg_hex_decode u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero && (sh_digits_nxt[4*k +: 4] == 4'h0);
            if (int'(idx_nxt) == k && all_zero) lz_blank = 1'b1;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= idx_nxt;
            if (boundary) blink_cnt <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
            blink_phase <= phase_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_blink  <= '0;
            pend       <= 1'b0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
        end else begin
            if (upd_i) begin
                stg_digits <= digits_i;
                stg_dp     <= dp_i;
                stg_blink  <= blink_i;
                pend       <= 1'b1;
            end else if (load) begin
                pend <= 1'b0;
            end
            sh_digits <= sh_digits_nxt;
            sh_dp     <= sh_dp_nxt;
            sh_blink  <= sh_blink_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments <= SEG_BLANK;
            anode    <= '1;
            dp       <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            frame_o <= boundary;
            if (tick) begin
                anode    <= ~(NUM_DIGITS'(1) << idx_nxt);
                segments <= (blink_blank || lz_blank) ? SEG_BLANK : dec_seg;
                dp       <= ~(sh_dp_nxt[idx_nxt] && !blink_blank);
            end
        end
    end

endmodule
